// File: rtl/apu_resp_buffer_pkg.sv
// Shared widths for the APU response buffer.
package apu_resp_buffer_pkg;

  localparam int unsigned APU_NUSFLAGS_CPU = 5;
  localparam int unsigned APU_DATA_W       = 32;

endpackage

// File: rtl/apu_resp_fifo.sv
// Circular result FIFO: registered head, push/pop in any state, drop-and-flag on full push.
module apu_resp_fifo
  import apu_resp_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = APU_DATA_W + APU_NUSFLAGS_CPU
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o    = (occ_q == '0);
  assign full       = (occ_q == OW'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  // A pop frees the head slot this cycle, so a full FIFO still accepts the push.
  assign do_push    = push_i & (~full | do_pop);
  assign overflow_o = push_i & full & ~do_pop;
  assign rdata_o    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/apu_resp_buffer.sv
// Credit-gated APU request path with a result FIFO absorbing the backpressure-free FPU result port.
module apu_resp_buffer
  import apu_resp_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned NUSFLAGS = APU_NUSFLAGS_CPU
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         core_req_i,
  output logic                         core_gnt_o,
  output logic                         fpu_req_o,
  input  logic                         fpu_gnt_i,
  input  logic                         fpu_rvalid_i,
  input  logic [APU_DATA_W-1:0]        fpu_rdata_i,
  input  logic [NUSFLAGS-1:0]          fpu_rflags_i,
  output logic                         core_rvalid_o,
  output logic [APU_DATA_W-1:0]        core_rdata_o,
  output logic [NUSFLAGS-1:0]          core_rflags_o,
  input  logic                         core_rready_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = APU_DATA_W + NUSFLAGS;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          credit_ok, issue, pop;
  logic          fifo_empty, fifo_ovf;
  logic [RW-1:0] head;

  // Credit check uses only the registered count: no path from fpu_gnt_i.
  assign credit_ok  = (cnt_q < CW'(DEPTH));
  assign fpu_req_o  = core_req_i & credit_ok;
  assign core_gnt_o = fpu_gnt_i & credit_ok;
  assign issue      = fpu_req_o & fpu_gnt_i;

  assign core_rvalid_o = ~fifo_empty;
  assign pop           = core_rvalid_o & core_rready_i;
  assign {core_rflags_o, core_rdata_o} = head;
  assign outstanding_o = cnt_q;
  assign overflow_o    = ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q | fifo_ovf;
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  apu_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (fpu_rvalid_i),
    .wdata_i    ({fpu_rflags_i, fpu_rdata_i}),
    .pop_i      (pop),
    .rdata_o    (head),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );

endmodule
